dmem_arbiter: RTL and testbench

//   Shares the single DataMemory port (iowrite, memwrite, addr, wdata, rdata) between two

---
 rtl/dmem_arbiter.sv | 153 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one DataMemory port between the CPU LSU (port 0) and the loader (port 1).
// Define DMEM_ARB_RR_EN for round-robin arbitration; by default port 0 has fixed priority.
`default_nettype none

module dmem_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic              io0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic              io1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_memwrite,
    output logic              mem_iowrite,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RDATA  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              win;
    logic              win_q;
    logic              we_q;
    logic              io_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              accept;

    assign accept = (state == S_IDLE) && (req0 || req1);

`ifdef DMEM_ARB_RR_EN
    logic rr_ptr;

    // On a tie the port that was not granted last goes next.
    always_comb begin
        win = req1;
        if (req0 && req1) begin
            win = ~rr_ptr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (accept) begin
            rr_ptr <= win;
        end
    end
`else
    always_comb begin
        win = req1 && !req0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        mem_memwrite = 1'b0;
        mem_iowrite  = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        case (state)
            S_IDLE: begin
                if (req0 || req1) begin
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // Bus is driven only from the latched request, never from req inputs.
                gnt0         = ~win_q;
                gnt1         = win_q;
                mem_memwrite = we_q & ~io_q;
                mem_iowrite  = we_q & io_q;
                mem_addr     = addr_q;
                mem_wdata    = wdata_q;
                state_nxt    = we_q ? S_IDLE : S_RDATA;
            end
            S_RDATA: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q   <= 1'b0;
            we_q    <= 1'b0;
            io_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            win_q   <= win;
            we_q    <= win ? we1 : we0;
            io_q    <= win ? io1 : io0;
            addr_q  <= win ? addr1 : addr0;
            wdata_q <= win ? wdata1 : wdata0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= (state == S_RDATA) && !win_q;
            rvalid1 <= (state == S_RDATA) && win_q;
            if ((state == S_RDATA) && !win_q) begin
                rdata0 <= mem_rdata;
            end
            if ((state == S_RDATA) && win_q) begin
                rdata1 <= mem_rdata;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: random and directed traffic on both ports, checked against a slot-level model.
`default_nettype none

module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  rq;
    logic        we_d    [2];
    logic        io_d    [2];
    logic [13:0] addr_d  [2];
    logic [31:0] wdata_d [2];

    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        mem_memwrite, mem_iowrite;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [1:0]  rv_w;
    logic [31:0] rd_w [2];
    assign rv_w    = {rvalid1, rvalid0};
    assign rd_w[0] = rdata0;
    assign rd_w[1] = rdata1;

    dmem_arbiter #(.ADDR_W(14), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(rq[0]), .we0(we_d[0]), .io0(io_d[0]), .addr0(addr_d[0]), .wdata0(wdata_d[0]),
        .req1(rq[1]), .we1(we_d[1]), .io1(io_d[1]), .addr1(addr_d[1]), .wdata1(wdata_d[1]),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_memwrite(mem_memwrite), .mem_iowrite(mem_iowrite),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // DataMemory stand-in: synchronous write, registered read
    logic [31:0] mem_arr [16384];
    logic        mem_clr = 1'b1;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16384; i++) mem_arr[i] <= '0;
        end else begin
            if (mem_memwrite) mem_arr[mem_addr] <= mem_wdata;
            mem_rdata <= mem_arr[mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // reference model state
    logic [31:0] ref_mem [16384];
    int          next_slot;
    int          last;
    int          rv_due  [2];
    logic [31:0] rv_data [2];
    logic [31:0] hold    [2];
    int          gcount  [2];
    int          drv_mode;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%h exp=%h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] bus_act();
        return {14'd0, gnt1, gnt0, mem_memwrite, mem_iowrite, mem_addr, mem_wdata};
    endfunction

    function automatic logic [63:0] exp_bus(input int p);
        if (p < 0) return 64'd0;
        return {14'd0, 1'(p == 1), 1'(p == 0), we_d[p] & ~io_d[p], we_d[p] & io_d[p],
                addr_d[p], wdata_d[p]};
    endfunction

    task automatic post(input int q, input logic w, input logic i,
                        input logic [13:0] a, input logic [31:0] d);
        rq[q]      = 1'b1;
        we_d[q]    = w;
        io_d[q]    = i;
        addr_d[q]  = a;
        wdata_d[q] = d;
    endtask

    task automatic model_reset();
        next_slot = 0;
        last      = 0;
        rq        = 2'b00;
        for (int q = 0; q < 2; q++) begin
            rv_due[q] = -1;
            hold[q]   = '0;
        end
    endtask

    // One cycle: a request visible at the sampling edge is granted in the next
    // cycle once the previous access has freed the bus (write 2, read 3 cycles).
    task automatic cycle_check(output int p);
        logic [63:0] e;
        logic        exp_rv;
        @(negedge clk);
        p = -1;
        if (cyc >= next_slot && rq != 2'b00) begin
            if (rq == 2'b11) p = RR ? ((last == 0) ? 1 : 0) : 0;
            else             p = rq[0] ? 0 : 1;
        end
        e = exp_bus(p);
        chk_val("bus", bus_act(), e);
        for (int q = 0; q < 2; q++) begin
            exp_rv = (rv_due[q] == cyc);
            if (exp_rv) hold[q] = rv_data[q];
            chk_val($sformatf("rvalid%0d", q), 64'(rv_w[q]), 64'(exp_rv));
            chk_val($sformatf("rdata%0d", q), 64'(rd_w[q]), 64'(hold[q]));
        end
        if (p >= 0) begin
            last = p;
            gcount[p]++;
            next_slot = cyc + (we_d[p] ? 2 : 3);
            if (we_d[p] && !io_d[p]) ref_mem[addr_d[p]] = wdata_d[p];
            if (!we_d[p]) begin
                rv_due[p]  = cyc + 2;
                rv_data[p] = ref_mem[addr_d[p]];
            end
            rq[p]      = 1'b0;
            we_d[p]    = 1'($urandom_range(0, 1));
            io_d[p]    = 1'($urandom_range(0, 1));
            addr_d[p]  = 14'($urandom);
            wdata_d[p] = $urandom;
            #1 chk_val("latch", bus_act(), e);
        end
    endtask

    task automatic drive(input int p);
        logic [13:0] a;
        for (int q = 0; q < 2; q++) begin
            if (!rq[q] && q != p) begin
                if (drv_mode == 1) begin
                    post(q, 1'b1, 1'b0, 14'h20 + 14'(q), $urandom);
                end else if (drv_mode == 2 && $urandom_range(0, 1) == 1) begin
                    case ($urandom_range(0, 3))
                        0:       a = 14'h0000;
                        1:       a = 14'h3FFF;
                        default: a = 14'($urandom_range(0, 15));
                    endcase
                    post(q, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), a, $urandom);
                end
            end
        end
    endtask

    task automatic run(input int n);
        int p;
        repeat (n) begin
            cycle_check(p);
            drive(p);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int          p;
        logic [31:0] old;
        rst_n    = 1'b0;
        drv_mode = 0;
        for (int q = 0; q < 2; q++) begin
            we_d[q] = 1'b0; io_d[q] = 1'b0; addr_d[q] = '0; wdata_d[q] = '0; gcount[q] = 0;
        end
        for (int i = 0; i < 16384; i++) ref_mem[i] = '0;
        model_reset();
        repeat (3) @(negedge clk);
        mem_clr = 1'b0;
        chk_val("rst_bus", bus_act(), 64'd0);
        chk_val("rst_rv", 64'(rv_w), 64'd0);
        chk_val("rst_rd0", 64'(rdata0), 64'd0);
        rst_n = 1'b1;

        // basic write then read-back on port 0
        post(0, 1'b1, 1'b0, 14'h0001, 32'd5);
        run(3);
        chk_val("t1_mem", 64'(mem_arr[1]), 64'd5);
        post(0, 1'b0, 1'b0, 14'h0001, 32'd0);
        run(4);
        chk_val("t2_rdata0", 64'(rdata0), 64'd5);

        // simultaneous reads
        post(0, 1'b0, 1'b0, 14'h0001, 32'd0);
        post(1, 1'b0, 1'b0, 14'h0001, 32'd0);
        cycle_check(p);
        chk_val("t3_first", 64'(p), RR ? 64'd1 : 64'd0);
        run(7);
        chk_val("t3_rdata1", 64'(rdata1), 64'd5);

        // IO write to top address leaves memory untouched
        post(1, 1'b1, 1'b1, 14'h3FFF, 32'hFFFF_FFFF);
        run(3);
        post(1, 1'b0, 1'b0, 14'h3FFF, 32'd0);
        run(4);
        chk_val("t5_rdata1", 64'(rdata1), 64'd0);
        chk_val("t5_mem", 64'(mem_arr[14'h3FFF]), 64'd0);

        // reset asserted while a write is on the bus
        old = ref_mem[14'h0010];
        post(0, 1'b1, 1'b0, 14'h0010, 32'h0000_ABCD);
        cycle_check(p);
        chk_val("t6_grant", 64'(p), 64'd0);
        ref_mem[14'h0010] = old;
        rst_n = 1'b0;
        #1;
        chk_val("t6_memwrite", 64'(mem_memwrite), 64'd0);
        chk_val("t6_gnt", 64'({gnt1, gnt0}), 64'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(3);
        post(0, 1'b0, 1'b0, 14'h0010, 32'd0);
        run(4);
        chk_val("t6_rdata0", 64'(rdata0), 64'(old));

        // both ports hammering writes
        gcount[0] = 0;
        gcount[1] = 0;
        drv_mode  = 1;
        post(0, 1'b1, 1'b0, 14'h0020, $urandom);
        post(1, 1'b1, 1'b0, 14'h0021, $urandom);
        run(16);
        chk_val("t4_gcount0", 64'(gcount[0]), RR ? 64'd4 : 64'd8);
        chk_val("t4_gcount1", 64'(gcount[1]), RR ? 64'd4 : 64'd0);
        drv_mode = 0;
        run(8);

        drv_mode = 2;
        run(2000);
        drv_mode = 0;
        run(10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
